// File: rtl/ping_pong_counter_param.sv
// Bidirectional bounce/wrap counter between runtime bounds lo..hi with
// synchronous load, direction flip and a one-cycle turnaround/wrap pulse.
module ping_pong_counter_param #(
    parameter int WIDTH   = 4,
    parameter bit RST_DIR = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             mode,
    input  logic             flip,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] out,
    output logic             direction,
    output logic             event_p
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic d_eff;
    logic bounds_bad;
    logic out_of_range;

    always_comb begin
        d_eff        = direction ^ flip;
        bounds_bad   = (lo >= hi);
        out_of_range = (out < lo) || (out > hi);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out       <= '0;
            direction <= RST_DIR;
            event_p   <= 1'b0;
        end else begin
            event_p <= 1'b0;
            if (load) begin
                out <= load_value;
            end else if (enable) begin
                if (bounds_bad) begin
                    out <= lo;
                end else if (out_of_range) begin
                    // Recover into range heading up; flip is deliberately ignored here.
                    out       <= lo;
                    direction <= 1'b1;
                end else if (d_eff) begin
                    if (out == hi) begin
                        event_p <= 1'b1;
                        if (mode) begin
                            out       <= lo;
                            direction <= 1'b1;
                        end else begin
                            out       <= hi - ONE;
                            direction <= 1'b0;
                        end
                    end else begin
                        out       <= out + ONE;
                        direction <= 1'b1;
                    end
                end else begin
                    if (out == lo) begin
                        event_p <= 1'b1;
                        if (mode) begin
                            out       <= hi;
                            direction <= 1'b0;
                        end else begin
                            out       <= lo + ONE;
                            direction <= 1'b1;
                        end
                    end else begin
                        out       <= out - ONE;
                        direction <= 1'b0;
                    end
                end
            end
        end
    end

endmodule
